control_unit_rv32: RTL and testbench

Registered main decoder for the RV32I single-issue datapath (`control_unit`). It takes the fetched 32-bit instruction and the branch-comparator flags (BrEq, BrLT), and produces every datapath select, enable and ALU-operation signal. All outputs are registered on the rising clock edge. The block sits between instruction fetch and the execute/memory/writeback datapath.

---
 rtl/control_pkg.sv | 67 ++++++
 rtl/control_decoder.sv | 64 ++++++
 rtl/control_unit_rv32.sv | 55 +++++
 tb/tb_control_unit_rv32.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared constants and the control bundle for the RV32I main decoder.
// Holds opcodes, ALU op codes, branch funct3 codes and the ctrl_t bundle.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [3:0] aluop;
    logic       wen;
    logic       immsel;
    logic       bsel;
    logic       brun;
    logic       asel;
    logic       pcsel;
    logic       wbsel;
    logic       memrw;
    logic       beq;
    logic       bne;
    logic       blt;
    logic       bge;
  } ctrl_t;

  // b30 picks SUB only when sub_ok (R-type); SRA/SRL always honours it.
  function automatic logic [3:0] alu_sel(
    input logic [2:0] f3,
    input logic       b30,
    input logic       sub_ok
  );
    logic [3:0] r;
    r = ALU_ADD;
    unique case (f3)
      3'b000: r = (sub_ok && b30) ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = b30 ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32I main decoder.
// In: Instruction, BrEq, BrLT. Out: nxt (next-state control bundle).
module control_decoder
  import control_pkg::*;
(
  input  logic [31:0] Instruction,
  input  logic        BrEq,
  input  logic        BrLT,
  output ctrl_t       nxt
);

  logic [6:0] op;
  logic [2:0] f3;
  logic       b30;

  assign op  = Instruction[6:0];
  assign f3  = Instruction[14:12];
  assign b30 = Instruction[30];

  // Register/immediate fields are consumed downstream, not here.
  logic unused_bits;
  assign unused_bits = ^{Instruction[31], Instruction[29:15],
                         Instruction[11:7]};

  always_comb begin
    nxt = '0;
    unique case (1'b1)
      (op == OP_R): begin
        nxt.wen   = 1'b1;
        nxt.aluop = alu_sel(f3, b30, 1'b1);
      end
      (op == OP_I): begin
        nxt.wen   = 1'b1;
        nxt.bsel  = 1'b1;
        nxt.aluop = alu_sel(f3, b30, 1'b0);
      end
      (op == OP_LOAD): begin
        nxt.wen   = 1'b1;
        nxt.bsel  = 1'b1;
        nxt.wbsel = 1'b1;
      end
      (op == OP_STORE): begin
        nxt.memrw  = 1'b1;
        nxt.bsel   = 1'b1;
        nxt.immsel = 1'b1;
      end
      (op == OP_BRANCH): begin
        nxt.asel   = 1'b1;
        nxt.bsel   = 1'b1;
        nxt.immsel = 1'b1;
        nxt.beq    = (f3 == F3_BEQ);
        nxt.bne    = (f3 == F3_BNE);
        nxt.blt    = (f3 == F3_BLT) || (f3 == F3_BLTU);
        nxt.bge    = (f3 == F3_BGE) || (f3 == F3_BGEU);
        nxt.brun   = (f3 == F3_BLTU) || (f3 == F3_BGEU);
      end
      default: ;
    endcase
    // Flags are zero outside branches, so this is 0 for every other class.
    nxt.pcsel = (nxt.beq & BrEq) | (nxt.bne & ~BrEq) |
                (nxt.blt & BrLT) | (nxt.bge & ~BrLT);
  end

endmodule

// File: rtl/control_unit_rv32.sv
// Registered RV32I control unit: decoder plus output register bank.
// In: clock, reset_n, Instruction, BrEq, BrLT. Out: datapath controls.
module control_unit_rv32
  import control_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] Instruction,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic [3:0]  ALUop,
  output logic        wEn,
  output logic        ImmSel,
  output logic        BSel,
  output logic        BrUn,
  output logic        ASel,
  output logic        PCSel,
  output logic        WBSel,
  output logic        MemRW,
  output logic        BEQ,
  output logic        BNE,
  output logic        BLT,
  output logic        BGE
);

  ctrl_t nxt;
  ctrl_t q;

  control_decoder u_dec (
    .Instruction (Instruction),
    .BrEq        (BrEq),
    .BrLT        (BrLT),
    .nxt         (nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= nxt;
  end

  assign ALUop  = q.aluop;
  assign wEn    = q.wen;
  assign ImmSel = q.immsel;
  assign BSel   = q.bsel;
  assign BrUn   = q.brun;
  assign ASel   = q.asel;
  assign PCSel  = q.pcsel;
  assign WBSel  = q.wbsel;
  assign MemRW  = q.memrw;
  assign BEQ    = q.beq;
  assign BNE    = q.bne;
  assign BLT    = q.blt;
  assign BGE    = q.bge;

endmodule

// File: tb/tb_control_unit_rv32.sv
// Scoreboard bench for control_unit_rv32.
// Driver queues hand-computed expectations; monitor checks after each edge.
module tb_control_unit_rv32;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] Instruction;
  logic        BrEq;
  logic        BrLT;
  logic [3:0]  ALUop;
  logic        wEn, ImmSel, BSel, BrUn, ASel, PCSel;
  logic        WBSel, MemRW, BEQ, BNE, BLT, BGE;

  control_unit_rv32 dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .Instruction (Instruction),
    .BrEq        (BrEq),
    .BrLT        (BrLT),
    .ALUop       (ALUop),
    .wEn         (wEn),
    .ImmSel      (ImmSel),
    .BSel        (BSel),
    .BrUn        (BrUn),
    .ASel        (ASel),
    .PCSel       (PCSel),
    .WBSel       (WBSel),
    .MemRW       (MemRW),
    .BEQ         (BEQ),
    .BNE         (BNE),
    .BLT         (BLT),
    .BGE         (BGE)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [15:0] got_vec();
    return {ALUop, wEn, ImmSel, BSel, BrUn, ASel, PCSel,
            WBSel, MemRW, BEQ, BNE, BLT, BGE};
  endfunction

  // Field order: alu wen imm bsel brun asel pcsel wbsel memrw beq bne blt bge
  function automatic logic [15:0] mk(
    input logic [3:0] alu,
    input bit wen, input bit imm, input bit bsel, input bit brun,
    input bit asel, input bit pcsel, input bit wbsel, input bit memrw,
    input bit beq, input bit bne, input bit blt, input bit bge
  );
    return {alu, wen, imm, bsel, brun, asel, pcsel,
            wbsel, memrw, beq, bne, blt, bge};
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] g;
    g = got_vec();
    checks++;
    if (g !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, g, exp);
    end
  endtask

  // Monitor: outputs are valid one edge after the driver issues a vector.
  always @(posedge clock) begin
    #2;
    if (reset_n === 1'b1 && sb.size() > 0) begin
      item_t e;
      e = sb.pop_front();
      check(e.name, e.exp);
    end
  end

  task automatic apply(input string name, input logic [31:0] ins,
                       input bit eq, input bit lt,
                       input logic [15:0] exp);
    item_t e;
    @(negedge clock);
    Instruction = ins;
    BrEq = eq;
    BrLT = lt;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
    #3;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset_n     = 1'b1;
    Instruction = 32'h0000_0033;
    BrEq        = 1'b0;
    BrLT        = 1'b0;
    repeat (2) @(posedge clock);
    // Async reset mid-cycle with a valid instruction present.
    #3 reset_n = 1'b0;
    #1 check("reset_async", 16'h0);
    @(posedge clock);
    #1 check("reset_hold", 16'h0);
    @(negedge clock);
    reset_n = 1'b1;

    apply("add",   32'h0000_0033, 0, 0, mk(4'd0,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("addi",  32'h0000_0013, 0, 0, mk(4'd0,1,0,1,0,0,0,0,0,0,0,0,0));
    apply("sub",   32'h4000_0033, 0, 0, mk(4'd1,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("srai",  32'h4000_5013, 0, 0, mk(4'd7,1,0,1,0,0,0,0,0,0,0,0,0));
    apply("addi30",32'h4000_0013, 0, 0, mk(4'd0,1,0,1,0,0,0,0,0,0,0,0,0));
    apply("sll",   32'h0000_1033, 0, 0, mk(4'd2,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("slt",   32'h0000_2033, 0, 0, mk(4'd3,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("sltiu", 32'h0000_3013, 0, 0, mk(4'd4,1,0,1,0,0,0,0,0,0,0,0,0));
    apply("xor",   32'h0000_4033, 0, 0, mk(4'd5,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("srl",   32'h0000_5033, 0, 0, mk(4'd6,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("sra",   32'h4000_5033, 0, 0, mk(4'd7,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("ori",   32'h0000_6013, 0, 0, mk(4'd8,1,0,1,0,0,0,0,0,0,0,0,0));
    apply("and",   32'h0000_7033, 0, 0, mk(4'd9,1,0,0,0,0,0,0,0,0,0,0,0));
    apply("beq_t", 32'h0000_0063, 1, 0, mk(4'd0,0,1,1,0,1,1,0,0,1,0,0,0));
    apply("beq_n", 32'h0000_0063, 0, 0, mk(4'd0,0,1,1,0,1,0,0,0,1,0,0,0));
    apply("bne_t", 32'h0000_1063, 0, 0, mk(4'd0,0,1,1,0,1,1,0,0,0,1,0,0));
    apply("bltu_t",32'h0000_6063, 0, 1, mk(4'd0,0,1,1,1,1,1,0,0,0,0,1,0));
    apply("bge_n", 32'h0000_5063, 0, 1, mk(4'd0,0,1,1,0,1,0,0,0,0,0,0,1));
    apply("bgeu_t",32'h0000_7063, 0, 0, mk(4'd0,0,1,1,1,1,1,0,0,0,0,0,1));
    apply("br_rsv",32'h0000_2063, 1, 1, mk(4'd0,0,1,1,0,1,0,0,0,0,0,0,0));
    apply("lw",    32'h0000_2003, 0, 0, mk(4'd0,1,0,1,0,0,0,1,0,0,0,0,0));
    apply("nop7f", 32'h0000_007F, 1, 1, mk(4'd0,0,0,0,0,0,0,0,0,0,0,0,0));
    apply("nop00", 32'h0000_0000, 0, 0, mk(4'd0,0,0,0,0,0,0,0,0,0,0,0,0));
    apply("sw",    32'h0000_2023, 0, 0, mk(4'd0,0,1,1,0,0,0,0,1,0,0,0,0));
    drain();

    // Outputs hold between edges when inputs change.
    @(posedge clock);
    #4;
    Instruction = 32'h0000_0033;
    BrEq = 1'b1;
    #1 check("hold", mk(4'd0,0,1,1,0,0,0,0,1,0,0,0,0));

    // Reset mid-operation after a taken branch.
    apply("beq_pre", 32'h0000_0063, 1, 0, mk(4'd0,0,1,1,0,1,1,0,0,1,0,0,0));
    drain();
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1 check("reset_mid", 16'h0);
    @(negedge clock);
    reset_n = 1'b1;
    apply("post_rst", 32'h0000_0013, 0, 0, mk(4'd0,1,0,1,0,0,0,0,0,0,0,0,0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
